pc_sum: RTL and testbench

- Program-counter increment adder for the monocycle CPU fetch path.
- Adds a fixed increment (default 8) to the current PC address and presents the result combinationally for next-PC selection.
- Also provides a registered copy of the sum and carry/overflow status for pipelined or debug consumers.
- Sits between the PC register and the next-PC mux.

---
 rtl/pc_pkg.sv | 6 +
 rtl/pc_sum_reg.sv | 16 +
 rtl/pc_sum.sv | 44 ++++
 tb/tb_pc_sum.sv | 81 ++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared PC width, increment and address type for the fetch path
package pc_pkg;
  localparam int PC_WIDTH = 32;
  localparam int PC_INC = 8;
  typedef logic [PC_WIDTH-1:0] pc_addr_t;
endpackage

// File: rtl/pc_sum_reg.sv
// pc_sum_reg: enable/sync-reset register bank for the registered pc_sum outputs
//   clk, rst : clock, synchronous active-high reset (clears q)
//   en       : load enable
//   d, q     : N-bit data in / registered data out
module pc_sum_reg #(
  parameter int N = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : en ? d : q;
endmodule

// File: rtl/pc_sum.sv
// pc_sum: PC increment adder, combinational sum/carry plus registered copies
//   clk, rst, en       : clock, sync active-high reset, register load enable
//   addrPC             : current PC address
//   outSUM, carry      : combinational addrPC + INC and its carry-out
//   outSUM_r, carry_r  : registered copies
//   sovf, sovf_r       : signed overflow and registered copy (only with PC_SUM_SOVF_EN)
module pc_sum
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int INC = PC_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] addrPC,
  output logic [WIDTH-1:0] outSUM,
  output logic [WIDTH-1:0] outSUM_r,
  output logic             carry,
`ifdef PC_SUM_SOVF_EN
  output logic             carry_r,
  output logic             sovf,
  output logic             sovf_r
`else
  output logic             carry_r
`endif
);
  assign {carry, outSUM} = {1'b0, addrPC} + (WIDTH+1)'(INC);
`ifdef PC_SUM_SOVF_EN
  // INC is positive, so overflow can only be a positive PC turning negative
  assign sovf = ~addrPC[WIDTH-1] & outSUM[WIDTH-1];
  pc_sum_reg #(.N(WIDTH+2)) u_reg (
    .clk(clk), .rst(rst), .en(en),
    .d({sovf, carry, outSUM}),
    .q({sovf_r, carry_r, outSUM_r})
  );
`else
  pc_sum_reg #(.N(WIDTH+1)) u_reg (
    .clk(clk), .rst(rst), .en(en),
    .d({carry, outSUM}),
    .q({carry_r, outSUM_r})
  );
`endif
endmodule

// File: tb/tb_pc_sum.sv
// tb_pc_sum: self-checking bench for pc_sum with a scoreboard on the registered path
module tb_pc_sum;
  import pc_pkg::*;
`ifdef PC_SUM_SOVF_EN
  localparam bit SOVF = 1'b1;
`else
  localparam bit SOVF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  pc_addr_t addrPC = '0;
  pc_addr_t outSUM, outSUM_r;
  logic carry, carry_r, sovf, sovf_r;
  int nTests = 0;
  int nFail = 0;
  logic [33:0] sb[$];
  logic [33:0] expR = '0;
  pc_sum dut (
    .clk(clk), .rst(rst), .en(en), .addrPC(addrPC),
    .outSUM(outSUM), .outSUM_r(outSUM_r),
`ifdef PC_SUM_SOVF_EN
    .carry(carry), .carry_r(carry_r), .sovf(sovf), .sovf_r(sovf_r)
`else
    .carry(carry), .carry_r(carry_r)
`endif
  );
`ifndef PC_SUM_SOVF_EN
  assign sovf = 1'b0;
  assign sovf_r = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] mdl(input pc_addr_t a);
    logic [32:0] s;
    s = {1'b0, a} + 33'd8;
    return {SOVF & ~a[31] & s[31], s};
  endfunction
  task automatic step(input logic r, input logic e, input pc_addr_t a);
    rst = r;
    en = e;
    addrPC = a;
    expR = r ? '0 : e ? mdl(a) : expR;
    sb.push_back(expR);
    @(posedge clk);
    #1;
    chk("reg", {sovf_r, carry_r, outSUM_r}, sb.pop_front());
  endtask
  pc_addr_t ca[6] = '{32'h0, 32'h4, 32'h10, 32'hFFFFFFF0, 32'hFFFFFFF8, 32'h7FFFFFFF};
  logic [33:0] ce[6] = '{{2'b00, 32'h8}, {2'b00, 32'hC}, {2'b00, 32'h18},
                         {2'b00, 32'hFFFFFFF8}, {2'b01, 32'h0}, {SOVF, 1'b0, 32'h80000007}};
  initial begin
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      addrPC = ca[i];
      #1;
      chk("comb", {sovf, carry, outSUM}, ce[i]);
    end
    @(negedge clk);
    step(1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h4);
    step(1'b0, 1'b0, 32'h10);
    chk("hold_comb", {sovf, carry, outSUM}, {2'b00, 32'h18});
    step(1'b1, 1'b1, 32'h10);
    step(1'b0, 1'b1, 32'h10);
    step(1'b0, 1'b1, 32'hFFFFFFF8);
    step(1'b0, 1'b1, 32'h7FFFFFFF);
    step(1'b1, 1'b0, 32'h7FFFFFFF);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
           i % 4 == 0 ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : 32'($urandom));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
